// File: rtl/axil_router_pkg.sv
// axil_router_pkg: response codes, FSM states and default client address map for axil_client_router.
package axil_router_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int MAX_NCLIENT = 16;
  localparam int DEF_NCLIENT = 5;
  localparam int DEF_ADDR_W = 18;
  localparam logic [DEF_NCLIENT*DEF_ADDR_W-1:0] DEF_BASE =
    {18'h12000, 18'h11000, 18'h02000, 18'h01000, 18'h00100};
  localparam logic [DEF_NCLIENT*DEF_ADDR_W-1:0] DEF_MASK =
    {18'h3F000, 18'h3F000, 18'h3F000, 18'h3F000, 18'h3FF00};
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/axil_router_decode.sv
// axil_router_decode: address to one-hot client select, lowest matching index wins.
module axil_router_decode #(
  parameter int NCLIENT = 5,
  parameter int ADDR_W = 18,
  parameter logic [NCLIENT*ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [NCLIENT*ADDR_W-1:0] ADDR_MASK = '0
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NCLIENT-1:0] sel,
  output logic               hit
);
  logic [NCLIENT-1:0] match;
  for (genvar i = 0; i < NCLIENT; i++) begin : g_match
    assign match[i] = (addr & ADDR_MASK[i*ADDR_W +: ADDR_W]) == BASE_ADDR[i*ADDR_W +: ADDR_W];
  end
  // isolating the lowest set bit gives priority to the lowest index
  assign sel = match & (~match + NCLIENT'(1));
  assign hit = |match;
endmodule

// File: rtl/axil_client_router.sv
// axil_client_router: routes AXI-lite style read/write starts to one-hot register clients.
// Optional ack timeout enabled by defining AXIL_ROUTER_TIMEOUT_EN.
module axil_client_router
  import axil_router_pkg::*;
#(
  parameter int NCLIENT = 5,
  parameter int ADDR_W = 18,
  parameter logic [NCLIENT*ADDR_W-1:0] BASE_ADDR = DEF_BASE,
  parameter logic [NCLIENT*ADDR_W-1:0] ADDR_MASK = DEF_MASK,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  axilClk,
  input  logic                  axilRst,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic                  rstart,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic                  wstart,
  input  logic                  bready,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  output logic [NCLIENT-1:0]    c_rstr,
  output logic [NCLIENT-1:0]    c_wstr,
  input  logic [NCLIENT-1:0]    c_rack,
  input  logic [NCLIENT-1:0]    c_wack,
  input  logic [NCLIENT*32-1:0] c_din,
  output logic [15:0]           timeout_cnt
);
`ifdef AXIL_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t r_st, r_nxt, w_st, w_nxt;
  logic [NCLIENT-1:0] r_sel, w_sel, r_dsel, w_dsel;
  logic r_hit, w_hit, r_ack, w_ack, r_to, w_to;
  logic [TW-1:0] r_cnt, w_cnt;
  logic [31:0] r_din;
  logic [15:0] tcnt;
  logic [16:0] t_sum;
  axil_router_decode #(.NCLIENT(NCLIENT), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .ADDR_MASK(ADDR_MASK))
    u_rdec (.addr(raddr), .sel(r_dsel), .hit(r_hit));
  axil_router_decode #(.NCLIENT(NCLIENT), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .ADDR_MASK(ADDR_MASK))
    u_wdec (.addr(waddr), .sel(w_dsel), .hit(w_hit));
  assign r_ack = |(c_rack & r_sel);
  assign w_ack = |(c_wack & w_sel);
  // an ack arriving in the same cycle as the deadline wins
  assign r_to = TO_EN && r_st == ST_PEND && !r_ack && r_cnt == TW'(TIMEOUT_CYC - 1);
  assign w_to = TO_EN && w_st == ST_PEND && !w_ack && w_cnt == TW'(TIMEOUT_CYC - 1);
  assign c_rstr = (r_st == ST_PEND) ? r_sel : '0;
  assign c_wstr = (w_st == ST_PEND) ? w_sel : '0;
  assign rvalid = r_st == ST_RESP;
  assign bvalid = w_st == ST_RESP;
  assign wready = w_st == ST_PEND && (w_ack || w_to);
  always_comb begin
    r_din = '0;
    for (int i = 0; i < NCLIENT; i++) r_din = r_din | (c_din[i*32 +: 32] & {32{r_sel[i]}});
  end
  always_comb begin
    r_nxt = r_st;
    if (r_st == ST_IDLE && rstart) r_nxt = r_hit ? ST_PEND : ST_RESP;
    if (r_st == ST_PEND && (r_ack || r_to)) r_nxt = ST_RESP;
    if (r_st == ST_RESP && rready) r_nxt = ST_IDLE;
  end
  always_comb begin
    w_nxt = w_st;
    if (w_st == ST_IDLE && wstart) w_nxt = w_hit ? ST_PEND : ST_RESP;
    if (w_st == ST_PEND && (w_ack || w_to)) w_nxt = ST_RESP;
    if (w_st == ST_RESP && bready) w_nxt = ST_IDLE;
  end
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      r_st <= ST_IDLE;
      r_sel <= '0;
      r_cnt <= '0;
      rdata <= '0;
      rresp <= '0;
    end else begin
      r_st <= r_nxt;
      if (r_st == ST_IDLE && rstart) begin
        r_sel <= r_dsel;
        r_cnt <= '0;
        rdata <= '0;
        rresp <= r_hit ? RESP_OKAY : RESP_DECERR;
      end
      if (r_st == ST_PEND) begin
        r_cnt <= r_cnt + TW'(1);
        rdata <= r_ack ? r_din : '0;
        rresp <= r_ack ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      w_st <= ST_IDLE;
      w_sel <= '0;
      w_cnt <= '0;
      bresp <= '0;
    end else begin
      w_st <= w_nxt;
      if (w_st == ST_IDLE && wstart) begin
        w_sel <= w_dsel;
        w_cnt <= '0;
        bresp <= w_hit ? RESP_OKAY : RESP_DECERR;
      end
      if (w_st == ST_PEND) begin
        w_cnt <= w_cnt + TW'(1);
        bresp <= w_ack ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
  assign t_sum = {1'b0, tcnt} + 17'(r_to) + 17'(w_to);
  always_ff @(posedge axilClk) begin
    if (axilRst) tcnt <= '0;
    else tcnt <= t_sum[16] ? 16'hFFFF : t_sum[15:0];
  end
  assign timeout_cnt = tcnt;
endmodule

// File: tb/tb_axil_client_router.sv
// tb_axil_client_router: directed stimulus with a transaction-level reference model checked every cycle.
// Timeout scenarios run when AXIL_ROUTER_TIMEOUT_EN is defined.
module tb_axil_client_router;
`ifdef AXIL_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 16;
  localparam int BASE_T [5] = '{'h00100, 'h01000, 'h02000, 'h11000, 'h12000};
  localparam int MASK_T [5] = '{'h3FF00, 'h3F000, 'h3F000, 'h3F000, 'h3F000};
  logic clk = 1'b0, axilRst = 1'b1;
  logic [17:0] raddr = '0, waddr = '0;
  logic rstart = 0, rready = 0, wstart = 0, bready = 0;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  logic rvalid, wready, bvalid;
  logic [4:0] c_rstr, c_wstr, c_rack = '0, c_wack = '0;
  logic [159:0] c_din = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001, 32'hCAFE0001};
  logic [15:0] timeout_cnt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  axil_client_router #(.NCLIENT(5), .ADDR_W(18), .TIMEOUT_CYC(TO)) dut (
    .axilClk(clk), .axilRst(axilRst), .raddr(raddr), .rstart(rstart), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .waddr(waddr), .wstart(wstart),
    .bready(bready), .wready(wready), .bresp(bresp), .bvalid(bvalid), .c_rstr(c_rstr),
    .c_wstr(c_wstr), .c_rack(c_rack), .c_wack(c_wack), .c_din(c_din), .timeout_cnt(timeout_cnt));
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic int decode(int a);
    for (int i = 0; i < 5; i++) if ((a & MASK_T[i]) == BASE_T[i]) return i;
    return -1;
  endfunction
  function automatic logic [31:0] stb(int c);
    return (c < 0) ? 32'd0 : (32'd1 << c);
  endfunction
  function automatic int sat(int t, logic a, logic b);
    return (t + int'(a) + int'(b) > 'hFFFF) ? 'hFFFF : t + int'(a) + int'(b);
  endfunction
  // reference model: which client is being strobed, how long it has waited, and the pending response
  int m_rcl = -1, m_wcl = -1, m_rwait = 0, m_wwait = 0, m_tc = 0;
  logic m_rv = 0, m_bv = 0;
  logic [31:0] m_rdata = '0;
  logic [1:0] m_rresp = '0, m_bresp = '0;
  logic m_rack, m_wack, m_rto, m_wto;
  assign m_rack = m_rcl >= 0 && c_rack[m_rcl[2:0]];
  assign m_wack = m_wcl >= 0 && c_wack[m_wcl[2:0]];
  assign m_rto = TO_EN && m_rcl >= 0 && !m_rack && m_rwait == TO - 1;
  assign m_wto = TO_EN && m_wcl >= 0 && !m_wack && m_wwait == TO - 1;
  always @(posedge clk) begin
    if (axilRst) begin
      m_rcl <= -1; m_wcl <= -1; m_rv <= 0; m_bv <= 0; m_tc <= 0;
    end else begin
      if (m_rv) begin
        if (rready) m_rv <= 0;
      end else if (m_rcl >= 0) begin
        if (m_rack) begin m_rcl <= -1; m_rv <= 1; m_rdata <= c_din[m_rcl*32 +: 32]; m_rresp <= 2'b00; end
        else if (m_rto) begin m_rcl <= -1; m_rv <= 1; m_rdata <= '0; m_rresp <= 2'b10; end
        else m_rwait <= m_rwait + 1;
      end else if (rstart) begin
        if (decode(int'(raddr)) < 0) begin m_rv <= 1; m_rdata <= '0; m_rresp <= 2'b11; end
        else begin m_rcl <= decode(int'(raddr)); m_rwait <= 0; end
      end
      if (m_bv) begin
        if (bready) m_bv <= 0;
      end else if (m_wcl >= 0) begin
        if (m_wack) begin m_wcl <= -1; m_bv <= 1; m_bresp <= 2'b00; end
        else if (m_wto) begin m_wcl <= -1; m_bv <= 1; m_bresp <= 2'b10; end
        else m_wwait <= m_wwait + 1;
      end else if (wstart) begin
        if (decode(int'(waddr)) < 0) begin m_bv <= 1; m_bresp <= 2'b11; end
        else begin m_wcl <= decode(int'(waddr)); m_wwait <= 0; end
      end
      m_tc <= sat(m_tc, m_rto, m_wto);
    end
  end
  always @(negedge clk) begin
    check("c_rstr", 32'(c_rstr), stb(m_rcl));
    check("c_wstr", 32'(c_wstr), stb(m_wcl));
    check("rvalid", 32'(rvalid), 32'(m_rv));
    check("bvalid", 32'(bvalid), 32'(m_bv));
    check("wready", 32'(wready), 32'(m_wcl >= 0 && (m_wack || m_wto)));
    check("timeout_cnt", 32'(timeout_cnt), m_tc);
    if (m_rv) begin
      check("rdata", rdata, m_rdata);
      check("rresp", 32'(rresp), 32'(m_rresp));
    end
    if (m_bv) check("bresp", 32'(bresp), 32'(m_bresp));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int nrv, nbv;
    repeat (3) step();
    check("rst_rstr", 32'(c_rstr), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", {28'd0, rresp, bresp}, 0);
    axilRst = 0;
    step();
    // read to client 0 with ack in the third strobe cycle
    raddr = 18'h00150; rstart = 1; step(); rstart = 0;
    for (int i = 0; i < 3; i++) begin
      check("rd_stb", 32'(c_rstr), 32'h1);
      if (i == 2) c_rack = 5'b00001;
      else step();
    end
    step(); c_rack = '0;
    check("rd_valid", 32'(rvalid), 1);
    check("rd_data", rdata, 32'hCAFE0001);
    check("rd_resp", 32'(rresp), 0);
    check("rd_stb_off", 32'(c_rstr), 0);
    step(); check("rd_hold", 32'(rvalid), 1);
    rready = 1; step(); rready = 0;
    check("rd_done", 32'(rvalid), 0);
    // write to client 3, unselected ack first, then bready held off
    waddr = 18'h11004; wstart = 1; step(); wstart = 0;
    check("wr_stb", 32'(c_wstr), 32'h8);
    c_wack = 5'b00001; step();
    check("wr_stb_held", 32'(c_wstr), 32'h8);
    c_wack = 5'b01000; #1;
    check("wr_wready", 32'(wready), 1);
    step(); c_wack = '0; #1;
    check("wr_wready_off", 32'(wready), 0);
    for (int i = 0; i < 4; i++) begin
      check("wr_bvalid", 32'(bvalid), 1);
      check("wr_bresp", 32'(bresp), 0);
      step();
    end
    check("wr_bvalid5", 32'(bvalid), 1);
    bready = 1; step(); bready = 0;
    check("wr_done", 32'(bvalid), 0);
    // decode error, then a start on the handshake cycle is dropped
    raddr = 18'h3F000; rstart = 1; step(); rstart = 0;
    check("de_valid", 32'(rvalid), 1);
    check("de_resp", 32'(rresp), 3);
    check("de_data", rdata, 0);
    check("de_stb", 32'(c_rstr), 0);
    rready = 1; rstart = 1; raddr = 18'h00100; step(); rready = 0; rstart = 0;
    check("hs_start_ign", 32'(c_rstr), 0);
    check("hs_valid", 32'(rvalid), 0);
    step();
    // concurrent read to client 1 and write to client 4
    raddr = 18'h01010; waddr = 18'h12345; rstart = 1; wstart = 1; step(); wstart = 0;
    check("cc_rstb", 32'(c_rstr), 32'h2);
    check("cc_wstb", 32'(c_wstr), 32'h10);
    raddr = 18'h00100; rready = 1; bready = 1; nrv = 0; nbv = 0;
    for (int i = 0; i < 10; i++) begin
      rstart = (i == 0);
      c_rack = (i == 1) ? 5'b00010 : 5'b0;
      c_wack = (i == 3) ? 5'b10000 : 5'b0;
      #1; nrv += int'(rvalid); nbv += int'(bvalid);
      step();
    end
    c_rack = '0; c_wack = '0; rready = 0; bready = 0;
    check("cc_nrvalid", nrv, 1);
    check("cc_nbvalid", nbv, 1);
    // reset during read PEND, late ack ignored, new start accepted at once
    raddr = 18'h02000; rstart = 1; step(); rstart = 0;
    check("rs_stb", 32'(c_rstr), 32'h4);
    step(); axilRst = 1; step();
    check("rs_stb_off", 32'(c_rstr), 0);
    check("rs_valid", 32'(rvalid), 0);
    axilRst = 0; rstart = 1; raddr = 18'h00100; c_rack = 5'b00100; step();
    rstart = 0; c_rack = '0;
    check("rs_new_stb", 32'(c_rstr), 32'h1);
    check("rs_no_valid", 32'(rvalid), 0);
    c_rack = 5'b00001; step(); c_rack = '0;
    check("rs_data", rdata, 32'hCAFE0001);
    rready = 1; step(); rready = 0;
`ifdef AXIL_ROUTER_TIMEOUT_EN
    raddr = 18'h01000; rstart = 1; step(); rstart = 0;
    for (int i = 0; i < TO; i++) begin
      check("to_stb", 32'(c_rstr), 32'h2);
      step();
    end
    check("to_stb_off", 32'(c_rstr), 0);
    check("to_rresp", 32'(rresp), 2);
    check("to_rdata", rdata, 0);
    check("to_cnt", 32'(timeout_cnt), 1);
    repeat (4) step();
    c_rack = 5'b00010; step(); c_rack = '0;
    check("to_late_resp", 32'(rresp), 2);
    check("to_late_data", rdata, 0);
    rready = 1; step(); rready = 0;
    waddr = 18'h02000; wstart = 1; step(); wstart = 0;
    repeat (TO - 1) step();
    check("wto_wready", 32'(wready), 1);
    step();
    check("wto_bresp", 32'(bresp), 2);
    check("wto_cnt", 32'(timeout_cnt), 2);
    bready = 1; step(); bready = 0;
`endif
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axil_client_router.md
AXIL_CLIENT_ROUTER -- requirements
Module: axil_client_router

Interface
REQ-001 Parameter NCLIENT, default 5: number of register clients, range 1..16.
REQ-002 Parameter ADDR_W, default 18: word-address width.
REQ-003 Parameter BASE_ADDR, default {18'h12000,18'h11000,18'h02000,18'h01000,18'h00100}: packed NCLIENT*ADDR_W base table, client 0 in the LSBs.
REQ-004 Parameter ADDR_MASK, default {18'h3F000,18'h3F000,18'h3F000,18'h3F000,18'h3FF00}: packed NCLIENT*ADDR_W mask table.
REQ-005 Parameter TIMEOUT_CYC, default 1024: cycles to wait for a client ack before the block returns an error.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 axilClk  in  1  sole clock; all logic on the rising edge.
REQ-008 axilRst  in  1  synchronous active-high reset.
REQ-009 raddr in ADDR_W, rstart in 1, rready in 1: read address, read start pulse, read-data accept.
REQ-010 rdata out 32, rresp out 2, rvalid out 1: read response.
REQ-011 waddr in ADDR_W, wstart in 1, bready in 1: write address, write start pulse, write-response accept.
REQ-012 wready out 1, bresp out 2, bvalid out 1: write-data accept pulse and write response.
REQ-013 c_rstr, c_wstr out NCLIENT: one-hot client read and write strobes.
REQ-014 c_rack, c_wack in NCLIENT: client read and write acks.
REQ-015 c_din in NCLIENT*32: client read data, client 0 in the LSBs.
REQ-016 timeout_cnt out 16: saturating count of timed-out transactions.

Function
REQ-017 Each direction SHALL run an independent FSM with states IDLE, PEND and RESP.
REQ-018 In IDLE, a start pulse SHALL decode the address as (addr & MASK[i]) == BASE[i]; the lowest matching index wins.
REQ-019 On a match, the FSM SHALL enter PEND and assert the selected strobe bit on the next cycle; only one strobe bit is ever high.
REQ-020 With no match, the FSM SHALL go directly to RESP with resp=2'b11 (DECERR), with the response valid 1 cycle after the start pulse; no strobe is asserted.
REQ-021 In PEND, the strobe SHALL be held until the selected client's ack is seen, then dropped on the next cycle; acks from unselected clients are ignored.
REQ-022 Read data SHALL be muxed from c_din of the selected client only, registered in the ack cycle; rvalid rises the following cycle with rresp=2'b00.
REQ-023 For writes, a write ack SHALL produce a single-cycle wready pulse; bvalid rises the cycle after wready with bresp=2'b00.
REQ-024 In RESP, rvalid/bvalid and the associated data/resp SHALL stay stable until rready/bready; on the handshake cycle the FSM returns to IDLE.
REQ-025 A start pulse while the FSM is not IDLE SHALL be ignored; a new start coinciding with the handshake cycle is also ignored.
REQ-026 Read and write FSMs SHALL operate concurrently with no interaction.
REQ-027 rdata SHALL be 32'h0 on any error response.

Reset
REQ-028 On axilRst, both FSMs SHALL go to IDLE and all strobes, rvalid, wready and bvalid SHALL be 0.
REQ-029 On axilRst, rdata, rresp and bresp SHALL be 0, the timeout counters SHALL be cleared, and timeout_cnt SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction silently; a client ack arriving after reset is ignored.

Configuration
REQ-031 Macro AXIL_ROUTER_TIMEOUT_EN, when defined: a per-direction counter runs in PEND.
REQ-032 With AXIL_ROUTER_TIMEOUT_EN, reaching TIMEOUT_CYC cycles without an ack SHALL drop the strobe and enter RESP with resp=2'b10 (SLVERR).
REQ-033 With AXIL_ROUTER_TIMEOUT_EN, a write timeout SHALL still issue the wready pulse before bvalid.
REQ-034 With AXIL_ROUTER_TIMEOUT_EN, timeout_cnt SHALL increment on each timeout and saturate at 16'hFFFF.
REQ-035 With AXIL_ROUTER_TIMEOUT_EN, a late ack after a timeout SHALL be ignored.
REQ-036 Without the macro, PEND SHALL wait indefinitely and timeout_cnt SHALL be tied to 0.

Structure
REQ-037 The package axil_router_pkg SHALL hold the RESP_OKAY/SLVERR/DECERR constants, the FSM state encoding, the default base and mask tables, and the maximum NCLIENT.
REQ-038 One sub-module, axil_router_decode, SHALL be used: combinational address-to-one-hot decoder with a hit flag, instantiated once per direction.

Verification
REQ-039 Read: raddr=18'h00150, client 0 acks 3 cycles after its strobe with c_din=32'hCAFE0001 -> c_rstr=5'b00001 for 3 cycles; rvalid the cycle after ack; rdata=32'hCAFE0001; rresp=0.
REQ-040 Write: waddr=18'h11004, client 3 acks -> c_wstr=5'b01000; one-cycle wready; bvalid next cycle with bresp=0; bready held low 4 cycles -> bvalid held 4 cycles.
REQ-041 Decode error: raddr=18'h3F000 -> no strobe; rvalid 1 cycle after rstart; rresp=2'b11; rdata=0.
REQ-042 Timeout, with macro and TIMEOUT_CYC=16: client never acks -> strobe drops after 16 cycles; rresp=2'b10; timeout_cnt=1; an ack injected 5 cycles later has no effect.
REQ-043 Concurrency: rstart to client 1 and wstart to client 4 on the same cycle -> both complete; a second rstart during PEND is ignored, giving exactly one rvalid.
REQ-044 Reset: axilRst asserted during a read PEND -> strobe low next cycle, rvalid stays 0, and the FSM accepts a new rstart immediately after reset.
